packet_link_mc: RTL and testbench

- Multi-channel successor to the single send/receive test pair.
- N_CH independent packet sources are round-robin arbitrated on `tick` onto one shared internal link.
- Each link word carries a channel ID and is steered into a per-channel receive FIFO of depth DEPTH.
- Credit-based flow control guarantees no receive FIFO ever overflows. Used as the packet-transport test core in the SoC test harness.

---
 rtl/packet_link_pkg.sv | 37 +++
 rtl/packet_chan_fifo.sv | 49 ++++
 rtl/packet_link_mc.sv | 124 ++++++++++++
 tb/tb_packet_link_mc.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/packet_link_pkg.sv
// Shared helpers for the multi-channel packet link: width helper and round-robin picker.
// PACKET_LINK_PARITY_EN (optional) adds link parity; this package is unaffected by it.
package packet_link_pkg;

  localparam int MAX_CH   = 16;
  localparam int MAX_ID_W = 4;

  typedef struct packed {
    logic                found;
    logic [MAX_ID_W-1:0] idx;
  } rr_pick_t;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Scan from rr_ptr upward, wrapping at n_ch; first eligible channel wins.
  function automatic rr_pick_t rr_pick(input logic [MAX_CH-1:0]   eligible,
                                       input logic [MAX_ID_W-1:0] rr_ptr,
                                       input int                  n_ch);
    rr_pick_t r;
    int       idx;
    r = '0;
    for (int i = 0; i < MAX_CH; i++) begin
      if (i < n_ch) begin
        idx = int'(rr_ptr) + i;
        if (idx >= n_ch) idx = idx - n_ch;
        if (!r.found && eligible[idx]) begin
          r.found = 1'b1;
          r.idx   = MAX_ID_W'(idx);
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/packet_chan_fifo.sv
// Per-channel first-word-fall-through receive FIFO; head reads as zero while empty.
// Depth must be a power of two so the pointers wrap naturally.
module packet_chan_fifo
  import packet_link_pkg::*;
#(
  parameter int PK_W  = 32,
  parameter int DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             wr_en,
  input  logic [PK_W-1:0]                  wr_data,
  input  logic                             rd_en,
  output logic [PK_W-1:0]                  rd_data,
  output logic                             empty,
  output logic [clog2_min1(DEPTH):0]       count
);

  localparam int PTR_W = clog2_min1(DEPTH);

  logic [PK_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push;
  logic             pop;

  assign empty   = (count == '0);
  assign push    = wr_en && (count != (PTR_W+1)'(DEPTH));
  assign pop     = rd_en && !empty;
  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/packet_link_mc.sv
// N_CH sources round-robin arbitrated onto one link register, steered into per-channel FIFOs
// with credit flow control. Define PACKET_LINK_PARITY_EN for link parity, parity_err, inject_err.
module packet_link_mc
  import packet_link_pkg::*;
#(
  parameter int PK_W  = 32,
  parameter int N_CH  = 4,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick,
  input  logic [N_CH-1:0]      input_buffer_empty,
  input  logic [N_CH*PK_W-1:0] packet_in,
  output logic [N_CH-1:0]      src_pop,
  input  logic [N_CH-1:0]      read_req,
  output logic [N_CH*PK_W-1:0] recv_packet_in,
  output logic [N_CH-1:0]      recv_input_buffer_empty,
  output logic [CNT_W-1:0]     sent_count
`ifdef PACKET_LINK_PARITY_EN
  ,
  input  logic                 inject_err,
  output logic                 parity_err
`endif
);

  localparam int CH_ID_W = clog2_min1(N_CH);
  localparam int PTR_W   = clog2_min1(DEPTH);

  typedef struct packed {
    logic               valid;
    logic [CH_ID_W-1:0] id;
    logic [PK_W-1:0]    data;
`ifdef PACKET_LINK_PARITY_EN
    logic               parity;
`endif
  } link_t;

  link_t              link_p0;
  link_t              link_p1;
  logic [CH_ID_W-1:0] rr_ptr;
  logic [N_CH-1:0]    eligible;
  logic [N_CH-1:0]    wr_en;
  rr_pick_t           pick;
  logic               grant;
  logic [CH_ID_W-1:0] gidx;
  logic [PK_W-1:0]    gdata;
  logic               wr_ok;

  // Grant stage: pick a channel and form the link word
  assign pick  = rr_pick(MAX_CH'(eligible), MAX_ID_W'(rr_ptr), N_CH);
  assign grant = tick && rst && pick.found;
  assign gidx  = pick.idx[CH_ID_W-1:0];
  assign gdata = packet_in[int'(gidx)*PK_W +: PK_W];

  always_comb begin
    src_pop = '0;
    if (grant) src_pop[gidx] = 1'b1;
  end

  always_comb begin
    link_p0       = '0;
    link_p0.valid = grant;
    link_p0.id    = gidx;
    link_p0.data  = gdata;
`ifdef PACKET_LINK_PARITY_EN
    link_p0.parity  = ^gdata;
    link_p0.data[0] = gdata[0] ^ inject_err;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      link_p1.valid <= 1'b0;
      rr_ptr        <= '0;
      sent_count    <= '0;
    end else begin
      link_p1 <= link_p0;
      if (grant) begin
        rr_ptr     <= (int'(gidx) == N_CH - 1) ? '0 : gidx + 1'b1;
        sent_count <= sent_count + 1'b1;
      end
    end
  end

  // Link stage: steer the word into its channel FIFO
`ifdef PACKET_LINK_PARITY_EN
  assign wr_ok = link_p1.valid && ((^link_p1.data) == link_p1.parity);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) parity_err <= 1'b0;
    else if (link_p1.valid && !wr_ok) parity_err <= 1'b1;
  end
`else
  assign wr_ok = link_p1.valid;
`endif

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    logic [PTR_W:0]   cnt;
    logic [PTR_W+1:0] credit;
    logic             in_flight;

    assign in_flight   = link_p1.valid && (link_p1.id == CH_ID_W'(c));
    assign credit      = (PTR_W+2)'(cnt) + (PTR_W+2)'(in_flight);
    assign eligible[c] = !input_buffer_empty[c] && (credit < (PTR_W+2)'(DEPTH));
    assign wr_en[c]    = wr_ok && (link_p1.id == CH_ID_W'(c));

    packet_chan_fifo #(
      .PK_W  (PK_W),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_en[c]),
      .wr_data (link_p1.data),
      .rd_en   (read_req[c]),
      .rd_data (recv_packet_in[c*PK_W +: PK_W]),
      .empty   (recv_input_buffer_empty[c]),
      .count   (cnt)
    );
  end

endmodule

// File: tb/tb_packet_link_mc.sv
// Directed bench for packet_link_mc (N_CH=4, DEPTH=4, PK_W=32): vector table plus reset/parity sequences.
module tb_packet_link_mc;

  localparam int PK_W  = 32;
  localparam int N_CH  = 4;
  localparam int DEPTH = 4;
  localparam int CNT_W = 16;

  logic                 clk;
  logic                 rst;
  logic                 tick;
  logic [N_CH-1:0]      input_buffer_empty;
  logic [N_CH*PK_W-1:0] packet_in;
  logic [N_CH-1:0]      src_pop;
  logic [N_CH-1:0]      read_req;
  logic [N_CH*PK_W-1:0] recv_packet_in;
  logic [N_CH-1:0]      recv_input_buffer_empty;
  logic [CNT_W-1:0]     sent_count;
`ifdef PACKET_LINK_PARITY_EN
  logic                 inject_err;
  logic                 parity_err;
`endif

  packet_link_mc #(.PK_W(PK_W), .N_CH(N_CH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk                     (clk),
    .rst                     (rst),
    .tick                    (tick),
    .input_buffer_empty      (input_buffer_empty),
    .packet_in               (packet_in),
    .src_pop                 (src_pop),
    .read_req                (read_req),
    .recv_packet_in          (recv_packet_in),
    .recv_input_buffer_empty (recv_input_buffer_empty),
    .sent_count              (sent_count)
`ifdef PACKET_LINK_PARITY_EN
    ,
    .inject_err              (inject_err),
    .parity_err              (parity_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rn;
    logic        t;
    logic [3:0]  ibe;
    logic [3:0]  rd;
    logic [31:0] pkt;
    logic [3:0]  pop;
    logic [3:0]  emp;
    logic [15:0] cnt;
    int          hch;
    logic [31:0] head;
  } vec_t;

  vec_t tbl[$];
  int   n_pass;
  int   n_total;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic vec_t mk(input logic rn, input logic t, input logic [3:0] ibe,
                              input logic [3:0] rd, input logic [31:0] pkt,
                              input logic [3:0] pop, input logic [3:0] emp,
                              input logic [15:0] cnt, input int hch, input logic [31:0] head);
    vec_t v;
    v.rn = rn; v.t = t; v.ibe = ibe; v.rd = rd; v.pkt = pkt;
    v.pop = pop; v.emp = emp; v.cnt = cnt; v.hch = hch; v.head = head;
    return v;
  endfunction

  function automatic logic [N_CH*PK_W-1:0] bcast(input logic [31:0] w);
    return {N_CH{w}};
  endfunction

  task automatic drive(input logic rn, input logic t, input logic [3:0] ibe,
                       input logic [3:0] rd, input logic [31:0] pkt);
    rst                = rn;
    tick               = t;
    input_buffer_empty = ibe;
    read_req           = rd;
    packet_in          = bcast(pkt);
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst = 1'b0; tick = 1'b0; input_buffer_empty = '1; read_req = '0; packet_in = '0;
`ifdef PACKET_LINK_PARITY_EN
    inject_err = 1'b0;
`endif

    // reset state, even with tick and sources present
    tbl.push_back(mk(0, 1, 4'h0, 4'h0, 32'h0,        4'h0, 4'hF, 16'd0, 0, 32'h0));
    // single packet on ch2
    tbl.push_back(mk(1, 1, 4'hB, 4'h0, 32'hDEADBEEF, 4'h4, 4'hF, 16'd1, -1, 32'h0));
    tbl.push_back(mk(1, 0, 4'hF, 4'h0, 32'h0,        4'h0, 4'hB, 16'd1, 2, 32'hDEADBEEF));
    tbl.push_back(mk(1, 0, 4'hF, 4'h4, 32'h0,        4'h0, 4'hF, 16'd1, -1, 32'h0));
    tbl.push_back(mk(0, 0, 4'hF, 4'h0, 32'h0,        4'h0, 4'hF, 16'd0, -1, 32'h0));
    // round robin across all four channels
    for (int i = 0; i < 8; i++) begin
      logic [3:0] e;
      e = (i == 0) ? 4'hF : (i == 1) ? 4'hE : (i == 2) ? 4'hC : (i == 3) ? 4'h8 : 4'h0;
      tbl.push_back(mk(1, 1, 4'h0, 4'h0, 32'h100 + 32'(i), 4'(1 << (i % 4)), e,
                       16'(i + 1), -1, 32'h0));
    end
    tbl.push_back(mk(1, 0, 4'hF, 4'h0, 32'h0, 4'h0, 4'h0, 16'd8, 0, 32'h100));
    tbl.push_back(mk(1, 0, 4'hF, 4'h1, 32'h0, 4'h0, 4'h0, 16'd8, 0, 32'h104));
    tbl.push_back(mk(0, 0, 4'hF, 4'h0, 32'h0, 4'h0, 4'hF, 16'd0, -1, 32'h0));
    // back-pressure: ch0 alone, no reads
    for (int i = 0; i < 10; i++) begin
      tbl.push_back(mk(1, 1, 4'hE, 4'h0, 32'h200 + 32'(i), (i < 4) ? 4'h1 : 4'h0,
                       (i == 0) ? 4'hF : 4'hE, (i < 4) ? 16'(i + 1) : 16'd4,
                       (i == 9) ? 0 : -1, 32'h200));
    end
    tbl.push_back(mk(1, 1, 4'hC, 4'h0, 32'h300, 4'h2, 4'hE, 16'd5, -1, 32'h0));
    tbl.push_back(mk(1, 0, 4'hF, 4'h0, 32'h0,   4'h0, 4'hC, 16'd5, 1, 32'h300));
    tbl.push_back(mk(0, 0, 4'hF, 4'h0, 32'h0,   4'h0, 4'hF, 16'd0, -1, 32'h0));
    // read/write collision on ch1 holding two words
    tbl.push_back(mk(1, 1, 4'hD, 4'h0, 32'h11, 4'h2, 4'hF, 16'd1, -1, 32'h0));
    tbl.push_back(mk(1, 1, 4'hD, 4'h0, 32'h12, 4'h2, 4'hD, 16'd2, -1, 32'h0));
    tbl.push_back(mk(1, 1, 4'hD, 4'h0, 32'h13, 4'h2, 4'hD, 16'd3, 1, 32'h11));
    tbl.push_back(mk(1, 0, 4'hF, 4'h2, 32'h0,  4'h0, 4'hD, 16'd3, 1, 32'h12));
    tbl.push_back(mk(1, 0, 4'hF, 4'h2, 32'h0,  4'h0, 4'hD, 16'd3, 1, 32'h13));
    tbl.push_back(mk(1, 0, 4'hF, 4'h2, 32'h0,  4'h0, 4'hF, 16'd3, -1, 32'h0));
    // pops on empty FIFOs, including one coinciding with a link write
    tbl.push_back(mk(1, 0, 4'hF, 4'hF, 32'h0,  4'h0, 4'hF, 16'd3, -1, 32'h0));
    tbl.push_back(mk(1, 1, 4'hE, 4'h0, 32'h77, 4'h1, 4'hF, 16'd4, -1, 32'h0));
    tbl.push_back(mk(1, 0, 4'hF, 4'h1, 32'h0,  4'h0, 4'hE, 16'd4, 0, 32'h77));
    tbl.push_back(mk(1, 0, 4'hF, 4'h1, 32'h0,  4'h0, 4'hF, 16'd4, -1, 32'h0));

    foreach (tbl[k]) begin
      @(negedge clk);
      drive(tbl[k].rn, tbl[k].t, tbl[k].ibe, tbl[k].rd, tbl[k].pkt);
      #1;
      check($sformatf("v%0d src_pop", k), 32'(src_pop), 32'(tbl[k].pop));
      @(posedge clk);
      #1;
      check($sformatf("v%0d empty", k), 32'(recv_input_buffer_empty), 32'(tbl[k].emp));
      check($sformatf("v%0d sent_count", k), 32'(sent_count), 32'(tbl[k].cnt));
      if (tbl[k].hch >= 0)
        check($sformatf("v%0d head ch%0d", k, tbl[k].hch),
              recv_packet_in[tbl[k].hch*PK_W +: PK_W], tbl[k].head);
    end

    // mid-operation asynchronous reset with a word in ch3 and another on the link
    @(negedge clk); drive(1, 1, 4'h7, 4'h0, 32'hABCD0003);
    @(negedge clk); drive(1, 0, 4'hF, 4'h0, 32'h0);
    @(posedge clk); #1;
    check("mid ch3 written", 32'(recv_input_buffer_empty), 32'h7);
    @(negedge clk); drive(1, 1, 4'h7, 4'h0, 32'h333);
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    check("async rst empty", 32'(recv_input_buffer_empty), 32'hF);
    check("async rst sent", 32'(sent_count), 32'h0);
    check("async rst pop", 32'(src_pop), 32'h0);
    check("async rst head", recv_packet_in[3*PK_W +: PK_W], 32'h0);
    @(negedge clk); drive(1, 0, 4'hF, 4'h0, 32'h0);
    @(posedge clk); #1;
    check("link discarded", 32'(recv_input_buffer_empty), 32'hF);
    check("post rst sent", 32'(sent_count), 32'h0);

`ifdef PACKET_LINK_PARITY_EN
    @(negedge clk); drive(1, 1, 4'hE, 4'h0, 32'h55); inject_err = 1'b1;
    #1; check("par grant pop", 32'(src_pop), 32'h1);
    @(negedge clk); drive(1, 0, 4'hF, 4'h0, 32'h0); inject_err = 1'b0;
    @(posedge clk); #1;
    check("par dropped", 32'(recv_input_buffer_empty), 32'hF);
    check("par err set", 32'(parity_err), 32'h1);
    @(negedge clk); drive(1, 1, 4'hE, 4'h0, 32'h56);
    #1; check("par regrant pop", 32'(src_pop), 32'h1);
    @(negedge clk); drive(1, 0, 4'hF, 4'h0, 32'h0);
    @(posedge clk); #1;
    check("par good write", 32'(recv_input_buffer_empty), 32'hE);
    check("par good head", recv_packet_in[0 +: PK_W], 32'h56);
    check("par err sticky", 32'(parity_err), 32'h1);
    @(negedge clk); rst = 1'b0; #1;
    check("par err reset", 32'(parity_err), 32'h0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
